// File: rtl/fibonacci_checker_if.sv
// Handshake bundle between a Fibonacci up/down stream source and its checker.
// The checker drives the status half; the source drives START/VALID/DATA.
interface fibonacci_checker_if #(
    parameter int n = 11
);
    logic         START;
    logic         VALID;
    logic [n-1:0] DATA;
    logic         BUSY;
    logic         DONE;
    logic         PASS;
    logic         ERR;
    logic [4:0]   ERR_IDX;
    logic [4:0]   TERM_CNT;

    modport master (
        output START, VALID, DATA,
        input  BUSY, DONE, PASS, ERR, ERR_IDX, TERM_CNT
    );

    modport slave (
        input  START, VALID, DATA,
        output BUSY, DONE, PASS, ERR, ERR_IDX, TERM_CNT
    );
endinterface

// File: rtl/fibonacci_checker.sv
// Receiver for a 16-term forward / 16-term reverse Fibonacci stream.
// Expected terms come from two history registers and one adder/subtractor.
module fibonacci_checker #(
    parameter int n = 11
) (
    input logic              CLK,
    input logic              RST,
    fibonacci_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FWD, REV, FIN} state_t;

    state_t       state_q, state_d;
    logic [n-1:0] histA_q, histA_d;
    logic [n-1:0] histB_q, histB_d;
    logic [n-1:0] addSub;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic         err_q, err_d;
    logic [4:0]   errIdx_q, errIdx_d;
    logic [4:0]   termCnt_q, termCnt_d;
    logic         accept;
    logic         mismatch;

    // histB_q always holds the term expected next; histA_q is its partner.
    assign addSub   = (state_q == REV) ? (histA_q - histB_q) : (histA_q + histB_q);
    assign accept   = bus.VALID && ((state_q == FWD) || (state_q == REV));
    assign mismatch = accept && (bus.DATA != histB_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            histA_q   <= '0;
            histB_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
            errIdx_q  <= '0;
            termCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            histA_q   <= histA_d;
            histB_q   <= histB_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            errIdx_q  <= errIdx_d;
            termCnt_q <= termCnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.START) state_d = FWD;
            FWD:     if (accept && (termCnt_q == 5'd15)) state_d = REV;
            REV:     if (accept && (termCnt_q == 5'd31)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        histA_d   = histA_q;
        histB_d   = histB_q;
        pass_d    = pass_q;
        err_d     = err_q;
        errIdx_d  = errIdx_q;
        termCnt_d = termCnt_q;
        busy_d    = (state_d == FWD) || (state_d == REV);
        done_d    = (state_d == FIN);

        // Seed {E0, E1} = {0, 1} so that E2 = E0 + E1 = 1.
        if ((state_q == IDLE) && bus.START) begin
            histA_d   = '0;
            histB_d   = {{(n-1){1'b0}}, 1'b1};
            pass_d    = 1'b0;
            err_d     = 1'b0;
            errIdx_d  = '0;
            termCnt_d = '0;
        end

        if (accept) begin
            termCnt_d = termCnt_q + 5'd1;
            if (mismatch) begin
                err_d = 1'b1;
                if (!err_q) errIdx_d = termCnt_q;
            end
            // Swapping {610, 987} to {987, 610} turns the pair around for the descent.
            if ((state_q == FWD) && (termCnt_q == 5'd15)) begin
                histA_d = histB_q;
                histB_d = histA_q;
            end else begin
                histA_d = histB_q;
                histB_d = addSub;
            end
            if ((state_q == REV) && (termCnt_q == 5'd31)) begin
                pass_d = !(err_q || mismatch);
            end
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.PASS     = pass_q;
    assign bus.ERR      = err_q;
    assign bus.ERR_IDX  = errIdx_q;
    assign bus.TERM_CNT = termCnt_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed self-checking bench for fibonacci_checker: clean, faulty, gapped,
// reset-interrupted and ignored-input scenarios against a hand-written term table.
module tb_fibonacci_checker;

    localparam int N = 11;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   doneEarly;
    int   busyLost;
    logic errAfter [32];
    int   expTerm  [32] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987,
                            610, 377, 233, 144, 89, 55, 34, 21, 13, 8, 5, 3, 2, 1, 1, 0};

    fibonacci_checker_if #(.n(N)) bus ();

    fibonacci_checker #(.n(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic startRun();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    // Sends terms first..last; indices badA/badB are corrupted by flipping bit 0.
    task automatic applyStimulus(input int first, input int last, input int badA,
                                 input int badB, input int maxGap);
        doneEarly = 0;
        busyLost  = 0;
        for (int i = first; i <= last; i++) begin
            bus.DATA  = N'(expTerm[i]);
            if (i == badA || i == badB) bus.DATA = bus.DATA ^ N'(1);
            bus.VALID = 1'b1;
            tick();
            bus.VALID   = 1'b0;
            errAfter[i] = bus.ERR;
            if (i < 31) begin
                if (bus.DONE) doneEarly++;
                if (!bus.BUSY) busyLost++;
                repeat ($urandom_range(maxGap, 0)) begin
                    tick();
                    if (bus.DONE) doneEarly++;
                    if (!bus.BUSY) busyLost++;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.START = 1'b0;
        bus.VALID = 1'b0;
        bus.DATA  = '0;
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.BUSY, bus.DONE, bus.PASS, bus.ERR} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags got %b want 0000", {bus.BUSY, bus.DONE, bus.PASS, bus.ERR});
        end
        checks++;
        if ({bus.ERR_IDX, bus.TERM_CNT} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_counts got idx=%0d cnt=%0d want 0/0", bus.ERR_IDX, bus.TERM_CNT);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_clean_run();
        startRun();
        checks++;
        if (bus.BUSY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clean_busy_start got %b want 1", bus.BUSY);
        end
        applyStimulus(0, 31, -1, -1, 0);
        checks++;
        if (doneEarly !== 0) begin
            failures++;
            $display("[TB] FAIL clean_done_early got %0d want 0", doneEarly);
        end
        checks++;
        if ({bus.DONE, bus.PASS, bus.ERR, bus.TERM_CNT} !== {3'b110, 5'd0}) begin
            failures++;
            $display("[TB] FAIL clean_final got done=%b pass=%b err=%b cnt=%0d want 1 1 0 0",
                     bus.DONE, bus.PASS, bus.ERR, bus.TERM_CNT);
        end
        tick();
        checks++;
        if ({bus.DONE, bus.BUSY, bus.PASS} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL clean_after got done=%b busy=%b pass=%b want 0 0 1",
                     bus.DONE, bus.BUSY, bus.PASS);
        end
    endtask

    task automatic test_single_error();
        startRun();
        checks++;
        if (bus.PASS !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_pass_cleared got %b want 0", bus.PASS);
        end
        applyStimulus(0, 31, 5, -1, 0);
        checks++;
        if ({errAfter[4], errAfter[5]} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL single_err_latency got %b%b want 01", errAfter[4], errAfter[5]);
        end
        checks++;
        if ({bus.DONE, bus.PASS, bus.ERR, bus.ERR_IDX} !== {3'b101, 5'd5}) begin
            failures++;
            $display("[TB] FAIL single_final got done=%b pass=%b err=%b idx=%0d want 1 0 1 5",
                     bus.DONE, bus.PASS, bus.ERR, bus.ERR_IDX);
        end
        tick();
    endtask

    task automatic test_gapped();
        startRun();
        checks++;
        if (bus.ERR !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gapped_err_cleared got %b want 0", bus.ERR);
        end
        applyStimulus(0, 31, -1, -1, 3);
        checks++;
        if (busyLost !== 0 || doneEarly !== 0) begin
            failures++;
            $display("[TB] FAIL gapped_busy got busyLost=%0d doneEarly=%0d want 0 0", busyLost, doneEarly);
        end
        checks++;
        if ({bus.DONE, bus.PASS, bus.ERR, bus.TERM_CNT} !== {3'b110, 5'd0}) begin
            failures++;
            $display("[TB] FAIL gapped_final got done=%b pass=%b err=%b cnt=%0d want 1 1 0 0",
                     bus.DONE, bus.PASS, bus.ERR, bus.TERM_CNT);
        end
        tick();
    endtask

    task automatic test_multi_error();
        startRun();
        applyStimulus(0, 31, 20, 30, 1);
        checks++;
        if ({errAfter[19], errAfter[20]} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL multi_err_onset got %b%b want 01", errAfter[19], errAfter[20]);
        end
        checks++;
        if ({bus.DONE, bus.PASS, bus.ERR, bus.ERR_IDX} !== {3'b101, 5'd20}) begin
            failures++;
            $display("[TB] FAIL multi_final got done=%b pass=%b err=%b idx=%0d want 1 0 1 20",
                     bus.DONE, bus.PASS, bus.ERR, bus.ERR_IDX);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int doneSeen = 0;
        startRun();
        applyStimulus(0, 9, 3, -1, 0);
        checks++;
        if ({bus.ERR, bus.TERM_CNT} !== {1'b1, 5'd10}) begin
            failures++;
            $display("[TB] FAIL midrst_before got err=%b cnt=%0d want 1 10", bus.ERR, bus.TERM_CNT);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({bus.BUSY, bus.ERR, bus.TERM_CNT} !== {2'b00, 5'd0}) begin
            failures++;
            $display("[TB] FAIL midrst_async got busy=%b err=%b cnt=%0d want 0 0 0",
                     bus.BUSY, bus.ERR, bus.TERM_CNT);
        end
        repeat (3) begin
            tick();
            if (bus.DONE) doneSeen++;
        end
        RST = 1'b0;
        repeat (2) begin
            tick();
            if (bus.DONE) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0) begin
            failures++;
            $display("[TB] FAIL midrst_done got %0d pulses want 0", doneSeen);
        end
        startRun();
        applyStimulus(0, 31, -1, -1, 0);
        checks++;
        if ({bus.DONE, bus.PASS, bus.ERR} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL midrst_rerun got done=%b pass=%b err=%b want 1 1 0",
                     bus.DONE, bus.PASS, bus.ERR);
        end
        tick();
    endtask

    task automatic test_ignored_inputs();
        bus.VALID = 1'b1;
        bus.DATA  = N'(1);
        tick();
        tick();
        checks++;
        if ({bus.BUSY, bus.ERR, bus.TERM_CNT} !== {2'b00, 5'd0}) begin
            failures++;
            $display("[TB] FAIL ign_idle_valid got busy=%b err=%b cnt=%0d want 0 0 0",
                     bus.BUSY, bus.ERR, bus.TERM_CNT);
        end
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.VALID = 1'b0;
        checks++;
        if ({bus.BUSY, bus.TERM_CNT} !== {1'b1, 5'd0}) begin
            failures++;
            $display("[TB] FAIL ign_start_valid got busy=%b cnt=%0d want 1 0", bus.BUSY, bus.TERM_CNT);
        end
        applyStimulus(0, 2, -1, -1, 0);
        bus.START = 1'b1;
        tick();
        tick();
        bus.START = 1'b0;
        checks++;
        if ({bus.BUSY, bus.ERR, bus.TERM_CNT} !== {2'b10, 5'd3}) begin
            failures++;
            $display("[TB] FAIL ign_busy_start got busy=%b err=%b cnt=%0d want 1 0 3",
                     bus.BUSY, bus.ERR, bus.TERM_CNT);
        end
        applyStimulus(3, 31, -1, -1, 0);
        checks++;
        if ({bus.DONE, bus.PASS, bus.ERR} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL ign_final got done=%b pass=%b err=%b want 1 1 0",
                     bus.DONE, bus.PASS, bus.ERR);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_single_error();
        test_gapped();
        test_multi_error();
        test_reset_mid();
        test_ignored_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fibonacci_checker.md
FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

Interface
REQ-001 Parameter: n, default 11, data width of each received term; SHALL be supported for n >= 11 only.
REQ-002 Port: CLK  in  1  system clock; all state SHALL change on its rising edge.
REQ-003 Port: RST  in  1  reset, asynchronous and active-high.
REQ-004 Port: START  in  1  level; sampled high in IDLE begins one 32-term check.
REQ-005 Port: VALID  in  1  DATA carries the next received term this cycle.
REQ-006 Port: DATA  in  n  received Fibonacci term, unsigned.
REQ-007 Port: BUSY  out  1  high while a check is in progress (FWD or REV).
REQ-008 Port: DONE  out  1  one-cycle pulse when a check completes.
REQ-009 Port: PASS  out  1  high after completion when all 32 terms matched; held until next START.
REQ-010 Port: ERR  out  1  sticky; set on the first mismatch, cleared only by START or RST.
REQ-011 Port: ERR_IDX  out  5  index (0-31) of the first mismatched term; held until next START.
REQ-012 Port: TERM_CNT  out  5  number of terms accepted in the current check, modulo 32.

Function
REQ-013 The block SHALL be the receiving end of the up/down Fibonacci stream: 16 forward terms, then 16 reverse terms.
REQ-014 The forward phase SHALL expect E1..E16 = 1,1,2,3,5,8,13,21,34,55,89,144,233,377,610,987, with Ek = Ek-1 + Ek-2 for k >= 3.
REQ-015 The reverse phase SHALL expect R1..R16 = 610,377,233,144,89,55,34,21,13,8,5,3,2,1,1,0, with R0 = 987 and Rk = Rk-2 - Rk-1.
REQ-016 Expected values SHALL be computed with two n-bit history registers and an n-bit adder/subtractor, never a lookup table; arithmetic is modulo 2^n.
REQ-017 States SHALL be IDLE, FWD, REV and FIN.
REQ-018 IDLE: outputs held. On START=1 -> FWD; on that edge clear ERR, PASS, ERR_IDX and TERM_CNT, and seed the history for E1.
REQ-019 FWD: each VALID=1 cycle compares DATA with the expected term, increments TERM_CNT and advances the history. The 16th accepted term -> REV with history {987, 610-predecessor} so the next expected term is R1.
REQ-020 REV: behaves like FWD using subtraction. The 16th accepted term (32nd overall) -> FIN.
REQ-021 FIN: DONE=1 for exactly one cycle; PASS <= ~ERR on entry to FIN; then -> IDLE.
REQ-022 VALID=0 cycles SHALL NOT advance any state. There is no timeout.
REQ-023 VALID in IDLE or FIN SHALL be ignored.
REQ-024 START while BUSY SHALL be ignored.
REQ-025 On a mismatch: set ERR; if ERR was previously 0, capture TERM_CNT (pre-increment) into ERR_IDX. Reception continues to term 32 regardless.
REQ-026 The history SHALL advance on the expected value, not on the received DATA, so that a single bad term does not cascade into further mismatches.
REQ-027 Comparison latency: ERR SHALL be visible the cycle after the mismatched VALID.
REQ-028 START and VALID both high in IDLE: START is taken, and VALID is ignored that cycle.
REQ-029 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-030 RST=1 SHALL immediately force IDLE and drive BUSY, DONE, PASS, ERR = 0 and ERR_IDX, TERM_CNT, history = 0, independent of CLK.
REQ-031 RST mid-check SHALL abandon the check without a DONE pulse; the next START begins a fresh check.

Verification
REQ-032 Clean run: START, then 32 VALID terms per REQ-014/015 back-to-back -> DONE pulses once, exactly 1 cycle after the 32nd term; PASS=1, ERR=0, TERM_CNT=0 (wrapped).
REQ-033 Single error: term 5 sent as 9 instead of 8 -> ERR=1 the next cycle, ERR_IDX=5; all later terms still match; at DONE, PASS=0.
REQ-034 Gapped VALID: random 0-3 idle cycles between terms -> same result as REQ-032; BUSY stays high throughout.
REQ-035 Multiple errors: mismatches at indices 20 and 30 -> ERR_IDX=20 (first only); PASS=0.
REQ-036 Reset mid-operation: RST asserted after term 10 -> BUSY=0 and ERR=0 immediately, no DONE; a following clean run per REQ-032 gives PASS=1.
REQ-037 Ignored inputs: START pulsed during FWD, and VALID sent in IDLE -> no effect on TERM_CNT, ERR or the sequence position.
